fp16_dot_accum: RTL
===================

Name: fp16_dot_accum

Overview:
- Downstream consumer of the FP16 multiplier: accepts a stream of FP16 products over a valid/ready handshake and sums them exactly.
- The running sum is held in a wide signed fixed-point (Kulisch-style) register scaled by 2^24, so there is no intermediate rounding.
- On the last beat of a vector it normalises and rounds the sum once (round-to-nearest-even) back to FP16, and emits it with flags and a beat count.
- It is the dot-product reduction stage of the PE.

Parameters:
- MAX_LEN_LOG2, 8: log2 of the maximum vector length; sets accumulator headroom and counter width.
- ACC_W, 41+MAX_LEN_LOG2: accumulator width in bits, signed two's complement. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  16  FP16 product (IEEE half)
- in_last  in  1  final beat of the vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  16  rounded FP16 sum
- out_nan  out  1  result is NaN
- out_inf  out  1  result is ±infinity, from an infinite input or from conversion overflow
- out_err  out  1  more than 2^MAX_LEN_LOG2 beats were received in this vector
- out_count  out  MAX_LEN_LOG2+1  beats in this vector, saturating

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Accumulator, counter and sticky flags are cleared. FSM goes to ACC.
- Reset mid-operation aborts any partial vector or pending result without emitting it.
- FSM states: ACC → NORM → RND → OUT → ACC.
- ACC state:
  - in_ready=1. A beat is accepted when in_valid&in_ready.
  - Decode: exponent field e, fraction f. Magnitude m = f if e==0, else (1024+f)<<(e-1). This is the value ×2^24, an unsigned 40-bit quantity.
  - The accumulator adds m or −m according to the sign bit.
  - count increments, saturating at 2^MAX_LEN_LOG2. An accepted beat while count is already at saturation sets sticky err.
  - e==31, f≠0: sets sticky nan. e==31, f==0: sets sticky pinf or ninf; not added to the accumulator.
  - An accepted beat with in_last=1 moves the FSM to NORM. The last beat is itself accumulated.
- NORM state:
  - in_ready=0.
  - Register sign and |acc|, and the MSB position p of |acc| (leading-one detect). p is undefined when |acc|==0.
- RND state: pack the result.
  - |acc|==0: result is +0 (0x0000).
  - p<10: subnormal. exp=0, frac=|acc|[9:0], exact.
  - p≥10: field = p−9. Mantissa = |acc|[p:p−10]. Guard bit = |acc|[p−11]; sticky = OR of all lower bits. Round to nearest even.
  - A mantissa carry-out increments field and resets the mantissa to 1.0.
  - field ≥ 31 after rounding: result is ±0x7C00 and inf=1.
  - Special-value overrides, in priority order:
    - nan set, or both pinf and ninf set: out_data=0x7E00, out_nan=1, out_inf=0.
    - else pinf or ninf set: out_data=0x7C00 or 0xFC00, out_inf=1.
- OUT state:
  - out_valid=1. out_data, flags and count are stable until out_valid&out_ready.
  - On that handshake: clear the accumulator, count and sticky flags, out_valid→0, return to ACC with in_ready=1 in the next cycle.
- Latency: beat with in_last accepted at edge t → out_valid high after edge t+3. Minimum vector-to-vector gap is 3 idle input cycles plus the output handshake cycle.
- Back-to-back: in_ready is 0 from NORM through OUT. No input is accepted while a result is pending.
- A single-beat vector (in_last on the first beat) is legal; count=1.
- Accumulator wrap-around is impossible at or below MAX_LEN beats. After err it is unspecified; out_err flags it.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16 field widths: EXP_W=5, FRAC_W=10, BIAS=15.
  - Constants QNAN=16'h7E00, PINF=16'h7C00, NINF=16'hFC00.
  - FSM state typedef {ACC, NORM, RND, OUT}.
- One sub-module, fp16_fx_pack. It is combinational: signed fixed-point magnitude + p → FP16 with RNE and an overflow flag. It is instantiated for the RND stage so it can be unit-tested alone.

Test Plan:
- Beats 0x3C00, 0x4000(last) → out_data=0x4200 (3.0), count=2; out_valid rises exactly 3 cycles after the last beat is accepted.
- Beats 0x3C00, 0xBC00(last) → 0x0000, nan=inf=0. Beats 0x0001 ×3 (last on third) → 0x0003, exact subnormal.
- RNE tie:
  - 0x3C00 + 0x1000(last) → 0x3C00 (tie rounds to even).
  - 0x3C01 + 0x1000(last) → 0x3C02.
- Overflow: 0x7BFF + 0x7BFF(last) → 0x7C00, out_inf=1. Specials:
  - 0x7C00 + 0xFC00(last) → 0x7E00, out_nan=1.
  - 0x7C00 + 0x3C00(last) → 0x7C00, out_inf=1.
- Backpressure: hold out_ready=0 for 5 cycles → out_data stable and in_ready=0 throughout. Assert reset while in OUT → out_valid=0, in_ready=1 next cycle, and the next vector starts from zero.
- Length limit (MAX_LEN_LOG2=2): 5 beats of 0x3C00 → out_err=1, out_count=4.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the PE datapath: field widths, special
// encodings, reduction FSM states and the product-beat magnitude decode.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;
    localparam logic [15:0] NINF = 16'hFC00;

    typedef enum logic [1:0] {ACC, NORM, RND, OUT} state_t;

    // Magnitude of a finite FP16 value scaled by 2^24, as an exact integer.
    // The smallest subnormal (2^-24) is weight 1, so every finite value fits in 40 bits.
    function automatic logic [39:0] beat_mag(input logic [14:0] x);
        logic [39:0] sig;
        sig = {29'd0, (x[14:10] != 5'd0), x[9:0]};
        return (x[14:10] == 5'd0) ? sig : sig << (x[14:10] - 5'd1);
    endfunction

endpackage

// File: rtl/fp16_fx_pack.sv
// Converts an unsigned fixed-point magnitude (scaled by 2^24) plus its
// leading-one position into FP16 with round-to-nearest-even.
module fp16_fx_pack
    import fp16_pkg::*;
#(
    parameter int MAG_W = 49,
    parameter int PW    = 6
) (
    input  logic             sign,
    input  logic [MAG_W-1:0] mag,
    input  logic [PW-1:0]    p,
    output logic [15:0]      result,
    output logic             overflow
);

    localparam logic [MAG_W-1:0] ONE = MAG_W'(1);

    logic [PW-1:0]     sh;
    logic [MAG_W-1:0]  half;
    logic [FRAC_W:0]   mant;
    logic              guard;
    logic              sticky;
    logic [FRAC_W+1:0] mant_r;
    logic [7:0]        field;

    // Pack: zero, exact subnormal, or normal with RNE and overflow to infinity.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred on any path.
        result   = 16'h0000;
        overflow = 1'b0;
        sh       = '0;
        half     = '0;
        mant     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        mant_r   = '0;
        field    = '0;
        if (mag == '0) begin
            result = 16'h0000;
        end else if (p < PW'(FRAC_W)) begin
            result = {sign, EXP_W'(0), mag[FRAC_W-1:0]};
        end else begin
            // sh is the number of bits that fall below the 11-bit mantissa.
            sh     = p - PW'(FRAC_W);
            mant   = (FRAC_W+1)'(mag >> sh);
            half   = (ONE << sh) >> 1;
            guard  = |(mag & half);
            sticky = |(mag & ((ONE << sh) - ONE) & ~half);
            mant_r = {1'b0, mant} + (FRAC_W+2)'(guard & (sticky | mant[0]));
            field  = 8'(p - PW'(FRAC_W - 1));
            if (mant_r[FRAC_W+1]) begin
                field = field + 8'd1;
            end
            if (field >= 8'd31) begin
                overflow = 1'b1;
                result   = {sign, PINF[14:0]};
            end else begin
                result = {sign, field[EXP_W-1:0], mant_r[FRAC_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/fp16_dot_accum.sv
// Dot-product reduction stage: exact fixed-point accumulation of FP16
// products, then a single normalise-and-round back to FP16 per vector.
module fp16_dot_accum
    import fp16_pkg::*;
#(
    parameter int MAX_LEN_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  out_nan,
    output logic                  out_inf,
    output logic                  out_err,
    output logic [MAX_LEN_LOG2:0] out_count
);

    // Derived widths; headroom grows with the maximum vector length.
    localparam int ACC_W = 41 + MAX_LEN_LOG2;
    localparam int PW    = $clog2(ACC_W);
    localparam int CW    = MAX_LEN_LOG2 + 1;
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {MAX_LEN_LOG2{1'b0}}};

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  beat_term;
    logic [ACC_W-1:0]         acc_abs;
    logic [PW-1:0]            lead;
    logic [CW-1:0]            count;
    logic                     nan_s, pinf_s, ninf_s, err_s;
    logic                     sign_r;
    logic [ACC_W-1:0]         mag_r;
    logic [PW-1:0]            p_r;
    logic [15:0]              pack_data;
    logic                     pack_ovf;
    logic                     beat_special;

    assign beat_special = (in_data[14:10] == 5'h1F);
    assign beat_term    = $signed({{(ACC_W-40){1'b0}}, beat_mag(in_data[14:0])});
    assign acc_abs      = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);

    // Leading-one detect on |acc|; the highest set bit wins.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc_abs[i]) lead = PW'(i);
        end
    end

    fp16_fx_pack #(.MAG_W(ACC_W), .PW(PW)) u_pack (
        .sign     (sign_r),
        .mag      (mag_r),
        .p        (p_r),
        .result   (pack_data),
        .overflow (pack_ovf)
    );

    // Reduction FSM: accumulate beats, latch |acc| and its MSB, pack, then hold the result.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
        if (reset) begin
            state     <= ACC;
            acc       <= '0;
            count     <= '0;
            nan_s     <= 1'b0;
            pinf_s    <= 1'b0;
            ninf_s    <= 1'b0;
            err_s     <= 1'b0;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            p_r       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_nan   <= 1'b0;
            out_inf   <= 1'b0;
            out_err   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid && in_ready) begin
                        if (beat_special) begin
                            // Infinities and NaNs only raise flags; they never touch the sum.
                            if (in_data[9:0] != 10'd0) nan_s  <= 1'b1;
                            else if (in_data[15])      ninf_s <= 1'b1;
                            else                       pinf_s <= 1'b1;
                        end else if (in_data[15]) begin
                            acc <= acc - beat_term;
                        end else begin
                            acc <= acc + beat_term;
                        end
                        if (count == MAX_LEN) err_s <= 1'b1;
                        else                  count <= count + 1'b1;
                        if (in_last) begin
                            state    <= NORM;
                            in_ready <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    sign_r <= acc[ACC_W-1];
                    mag_r  <= acc_abs;
                    p_r    <= lead;
                    state  <= RND;
                end
                RND: begin
                    if (nan_s || (pinf_s && ninf_s)) begin
                        out_data <= QNAN;
                        out_nan  <= 1'b1;
                        out_inf  <= 1'b0;
                    end else if (pinf_s || ninf_s) begin
                        out_data <= pinf_s ? PINF : NINF;
                        out_nan  <= 1'b0;
                        out_inf  <= 1'b1;
                    end else begin
                        out_data <= pack_data;
                        out_nan  <= 1'b0;
                        out_inf  <= pack_ovf;
                    end
                    out_err   <= err_s;
                    out_count <= count;
                    state     <= OUT;
                end
                OUT: begin
                    // The result registers settled on entry; valid follows one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        acc       <= '0;
                        count     <= '0;
                        nan_s     <= 1'b0;
                        pinf_s    <= 1'b0;
                        ninf_s    <= 1'b0;
                        err_s     <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
